// File: rtl/sap2_loader_pkg.sv
// Shared types and frame constants for the SAP-2 program loader.
// The S_CSUM state only exists when LOADER_CSUM_EN is defined.
package sap2_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_ADDR,
        S_DATA
`ifdef LOADER_CSUM_EN
        , S_CSUM
`endif
    } loader_state_t;

    // A LEN byte of zero encodes a full sweep of the address space.
    localparam bit LEN_ZERO_MEANS_FULL = 1'b1;

endpackage

// File: rtl/sap2_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with registered one-cycle
// rise and fall pulses taken from the synchronized level.
module sap2_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~prev_q;
            fall   <= ~sync_q[STAGES-1] & prev_q;
        end
    end

endmodule

// File: rtl/sap2_prog_loader.sv
// Loads a framed host byte stream into SAP-2 program memory while holding the CPU in reset.
// Build option LOADER_CSUM_EN appends an XOR checksum byte to every frame.
//
// state  | meaning
// S_IDLE | no session; waits for a LOAD_REQ rising edge, strobes acked and discarded
// S_LEN  | next byte is the frame length (0 = full address space)
// S_ADDR | next byte is the start address
// S_DATA | each byte is written to memory, address increments and wraps
// S_CSUM | next byte is compared with the running XOR (LOADER_CSUM_EN only)
module sap2_prog_loader
    import sap2_loader_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LOAD_REQ,
    input  logic              STB,
    input  logic [7:0]        DIN,
    output logic              ACK,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [7:0]        MEM_DATA,
    output logic              MEM_WE,
    output logic              CPU_HOLD,
    output logic              DONE,
    output logic              ERR
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] LEN_FULL = CW'(1) << ADDR_W;

    logic stb_rise, stb_fall, req_rise, req_fall;
    logic byte_take;
    logic start, load_len, load_addr, wr_byte, done_set, err_set;

    loader_state_t     state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] addr_cnt;

    sap2_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_stb (
        .clk      (CLK),
        .rst      (RST),
        .async_in (STB),
        .rise     (stb_rise),
        .fall     (stb_fall)
    );

    sap2_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_req (
        .clk      (CLK),
        .rst      (RST),
        .async_in (LOAD_REQ),
        .rise     (req_rise),
        .fall     (req_fall)
    );

    // A rise while ACK is still high is a host protocol violation and is dropped.
    assign byte_take = stb_rise & ~ACK;

`ifdef LOADER_CSUM_EN
    logic [7:0] acc;

    always_ff @(posedge CLK) begin
        if (RST || start) begin
            acc <= 8'h00;
        end else if (load_len || load_addr || wr_byte) begin
            acc <= acc ^ DIN;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        load_len  = 1'b0;
        load_addr = 1'b0;
        wr_byte   = 1'b0;
        done_set  = 1'b0;
        err_set   = 1'b0;
        case (state)
            S_IDLE: if (req_rise) begin
                start     = 1'b1;
                state_nxt = S_LEN;
            end
            S_LEN: if (byte_take) begin
                load_len  = 1'b1;
                state_nxt = S_ADDR;
            end
            S_ADDR: if (byte_take) begin
                load_addr = 1'b1;
                state_nxt = S_DATA;
            end
            S_DATA: if (byte_take) begin
                wr_byte = 1'b1;
                if (cnt == CW'(1)) begin
`ifdef LOADER_CSUM_EN
                    state_nxt = S_CSUM;
`else
                    done_set  = 1'b1;
                    state_nxt = S_IDLE;
`endif
                end
            end
`ifdef LOADER_CSUM_EN
            S_CSUM: if (byte_take) begin
                if (acc == DIN) done_set = 1'b1;
                else            err_set  = 1'b1;
                state_nxt = S_IDLE;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase

        // Abort outranks any byte arriving in the same cycle.
        if (state != S_IDLE && req_fall) begin
            load_len  = 1'b0;
            load_addr = 1'b0;
            wr_byte   = 1'b0;
            done_set  = 1'b0;
            err_set   = 1'b1;
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            addr_cnt <= '0;
            ACK      <= 1'b0;
            MEM_WE   <= 1'b0;
            MEM_ADDR <= '0;
            MEM_DATA <= 8'h00;
            CPU_HOLD <= 1'b1;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            state  <= state_nxt;
            MEM_WE <= wr_byte;

            if (stb_fall)      ACK <= 1'b0;
            else if (stb_rise) ACK <= 1'b1;

            if (start) begin
                DONE     <= 1'b0;
                ERR      <= 1'b0;
                CPU_HOLD <= 1'b1;
            end
            if (done_set) begin
                DONE     <= 1'b1;
                CPU_HOLD <= 1'b0;
            end
            if (err_set) ERR <= 1'b1;

            if (load_len)
                cnt <= (LEN_ZERO_MEANS_FULL && DIN == 8'h00) ? LEN_FULL : CW'(DIN);
            if (load_addr)
                addr_cnt <= ADDR_W'(DIN);
            if (wr_byte) begin
                MEM_ADDR <= addr_cnt;
                MEM_DATA <= DIN;
                addr_cnt <= addr_cnt + ADDR_W'(1);
                cnt      <= cnt - CW'(1);
            end
        end
    end

endmodule
